elevador_scan: RTL and testbench
================================

ELEVADOR_SCAN -- requirements
Module: elevador_scan

Interface
REQ-001 Parameter N_FLOORS, default 8, number of floors (legal range 2..16).
REQ-002 Parameter TRAVEL_CYCLES, default 2, clock cycles needed to move one floor (legal minimum 1).
REQ-003 Parameter DOOR_CYCLES, default 4, clock cycles the door stays open (legal minimum 1).
REQ-004 Parameter CAPACITY, default 10, maximum legal occupancy.
REQ-005 Derived widths SHALL be: FLOOR_W = clog2(N_FLOORS); CNT_W = clog2(CAPACITY+2).
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 req  in  N_FLOORS  floor call pulses; bit i requests floor i.
REQ-009 person_enter  in  1  one person entered this cycle.
REQ-010 person_exit  in  1  one person left this cycle.
REQ-011 motor_up  out  1  car is moving up.
REQ-012 motor_down  out  1  car is moving down.
REQ-013 door_open  out  1  door is open.
REQ-014 andar_atual  out  FLOOR_W  current floor.
REQ-015 pending  out  N_FLOORS  latched requests not yet served.
REQ-016 num_people  out  CNT_W  occupancy count.
REQ-017 overload  out  1  high when num_people > CAPACITY.

Function
REQ-018 The controller SHALL be a Moore FSM with states IDLE, MOVING_UP, MOVING_DOWN and DOOR_OPEN, plus a direction register dir (UP or DOWN).
REQ-019 pending SHALL be set on the edge after req[i]=1 (pending |= req) and SHALL hold until served; a pending bit is cleared only on entry to DOOR_OPEN at that floor.
REQ-020 A req bit for andar_atual arriving while in DOOR_OPEN SHALL NOT be latched and SHALL reload the door timer to DOOR_CYCLES.
REQ-021 IDLE transitions, in priority order:
- pending[andar_atual] set -> DOOR_OPEN.
- Request above and (dir=UP or no request below) -> MOVING_UP, dir=UP.
- Request below -> MOVING_DOWN, dir=DOWN.
- Otherwise -> stay in IDLE.
REQ-022 In a MOVING state the travel counter SHALL count TRAVEL_CYCLES; on expiry andar_atual SHALL move ±1, and the next state is DOOR_OPEN if pending is set at the new floor, otherwise the same MOVING state.
REQ-023 andar_atual SHALL never leave 0..N_FLOORS-1.
REQ-024 The car SHALL never reverse direction while requests remain ahead of it (SCAN order).
REQ-025 motor_up=1 exactly when in MOVING_UP; motor_down=1 exactly when in MOVING_DOWN; door_open=1 exactly when in DOOR_OPEN; these three outputs are mutually exclusive.
REQ-026 The door timer SHALL load DOOR_CYCLES on entry to DOOR_OPEN and decrement each cycle only while overload=0; on expiry the FSM -> IDLE.
REQ-027 Latency: a req pulse at cycle t sets pending at t+1; the earliest state change out of IDLE occurs at t+2.
REQ-028 person_enter and person_exit SHALL count only while door_open=1 and are ignored otherwise.
REQ-029 Occupancy counter rules:
- enter and exit in the same cycle -> no change.
- Increment saturates at 2^CNT_W-1.
- Decrement saturates at 0.

Reset
REQ-030 Asserting reset at any time, including mid-travel or with the door open, SHALL force within the same cycle: state=IDLE, dir=UP, andar_atual=0, pending=0, num_people=0, both timers=0, and all outputs to 0.

Structure
REQ-031 Package elevador_pkg SHALL hold the state encoding (2 bits) and the dir constants UP and DOWN.
REQ-032 The occupancy counter SHALL be a sub-module elevador_people_counter (parameter CAPACITY; outputs num_people and overload).
REQ-033 "Request above" and "request below" SHALL be combinational masks of pending relative to andar_atual.

Verification (N_FLOORS=8, TRAVEL_CYCLES=2, DOOR_CYCLES=4, CAPACITY=10)
REQ-034 After reset, pulse req=0x20 -> pending=0x20 next cycle; motor_up for 10 cycles; andar_atual steps 0..5; door_open 4 cycles; pending=0.
REQ-035 Car moving up at floor 3 toward 6; pulse req[1] and req[5] -> stops at 5, then 6, then moves down to 1; visit order 5, 6, 1.
REQ-036 Idle at floor 2; pulse req[2] -> door_open with no motor pulse; a repeat req[2] during door_open extends door_open to 4 cycles after the repeat.
REQ-037 11 person_enter pulses during door_open -> num_people=11, overload=1, door held open indefinitely; one exit -> num_people=10, overload=0, door closes after the remaining timer.
REQ-038 Counter edge cases:
- Simultaneous enter and exit -> count unchanged.
- Enter while door closed -> ignored.
- Exit at 0 -> stays 0.
REQ-039 Assert reset mid-travel at floor 4 with pending=0x81 -> everything returns to its reset values asynchronously, with no motor output the following cycle.

Source files
------------

// File: rtl/elevador_pkg.sv
// Shared encodings for the SCAN elevator controller: FSM state and travel direction.
package elevador_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        MOVING_UP   = 2'd1,
        MOVING_DOWN = 2'd2,
        DOOR_OPEN   = 2'd3
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/elevador_people_counter.sv
// Car occupancy counter: counts boarding/leaving only while enabled (door open),
// saturating at both ends, and flags occupancy above CAPACITY.
module elevador_people_counter #(
    parameter int  CAPACITY = 10,
    localparam int CNT_W    = $clog2(CAPACITY + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_en,
    input  logic             person_enter,
    input  logic             person_exit,
    output logic [CNT_W-1:0] num_people,
    output logic             overload
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Simultaneous enter and exit cancel out.
    always_comb begin
        count_d = count_q;
        if (count_en && person_enter && !person_exit && count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
        end else if (count_en && person_exit && !person_enter && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign num_people = count_q;
    assign overload   = (count_q > CNT_W'(CAPACITY));

endmodule

// File: rtl/elevador_scan.sv
// SCAN-order elevator controller: latches floor calls, keeps travelling in one
// direction while calls remain ahead, and holds the door while overloaded.
module elevador_scan
    import elevador_pkg::*;
#(
    parameter int  N_FLOORS      = 8,
    parameter int  TRAVEL_CYCLES = 2,
    parameter int  DOOR_CYCLES   = 4,
    parameter int  CAPACITY      = 10,
    localparam int FLOOR_W       = $clog2(N_FLOORS),
    localparam int CNT_W         = $clog2(CAPACITY + 2)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] req,
    input  logic                person_enter,
    input  logic                person_exit,
    output logic                motor_up,
    output logic                motor_down,
    output logic                door_open,
    output logic [FLOOR_W-1:0]  andar_atual,
    output logic [N_FLOORS-1:0] pending,
    output logic [CNT_W-1:0]    num_people,
    output logic                overload
);

    localparam int TRAV_W = $clog2(TRAVEL_CYCLES + 1);
    localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);
    localparam logic [TRAV_W-1:0]  TRAVEL_LAST = TRAV_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]  DOOR_LOAD   = DOOR_W'(DOOR_CYCLES);
    localparam logic [FLOOR_W-1:0] FLOOR_TOP   = FLOOR_W'(N_FLOORS - 1);

    state_t              state_q, state_d;
    dir_t                dir_q, dir_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [TRAV_W-1:0]   travel_q, travel_d;
    logic [DOOR_W-1:0]   door_q, door_d;

    logic [N_FLOORS-1:0] cur_hit;
    logic [N_FLOORS-1:0] above_mask;
    logic [N_FLOORS-1:0] below_mask;
    logic [N_FLOORS-1:0] clear_mask;
    logic [N_FLOORS-1:0] req_eff;

    for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_mask
        assign cur_hit[gi]    = (floor_q == FLOOR_W'(gi));
        assign above_mask[gi] = pending_q[gi] && (FLOOR_W'(gi) > floor_q);
        assign below_mask[gi] = pending_q[gi] && (FLOOR_W'(gi) < floor_q);
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        floor_d    = floor_q;
        travel_d   = travel_q;
        door_d     = door_q;
        clear_mask = '0;
        // A call for the floor whose door is already open is absorbed, not latched.
        req_eff    = (state_q == DOOR_OPEN) ? (req & ~cur_hit) : req;

        case (state_q)
            IDLE: begin
                travel_d = '0;
                if (|(pending_q & cur_hit)) begin
                    state_d    = DOOR_OPEN;
                    clear_mask = cur_hit;
                    door_d     = DOOR_LOAD;
                end else if (|above_mask && (dir_q == UP || !(|below_mask))) begin
                    state_d = MOVING_UP;
                    dir_d   = UP;
                end else if (|below_mask) begin
                    state_d = MOVING_DOWN;
                    dir_d   = DOWN;
                end
            end
            MOVING_UP: begin
                if (floor_q == FLOOR_TOP) begin
                    state_d  = IDLE;
                    travel_d = '0;
                end else if (travel_q == TRAVEL_LAST) begin
                    travel_d = '0;
                    floor_d  = floor_q + 1'b1;
                    if (|(pending_q & (cur_hit << 1))) begin
                        state_d    = DOOR_OPEN;
                        clear_mask = cur_hit << 1;
                        door_d     = DOOR_LOAD;
                    end
                end else begin
                    travel_d = travel_q + 1'b1;
                end
            end
            MOVING_DOWN: begin
                if (floor_q == '0) begin
                    state_d  = IDLE;
                    travel_d = '0;
                end else if (travel_q == TRAVEL_LAST) begin
                    travel_d = '0;
                    floor_d  = floor_q - 1'b1;
                    if (|(pending_q & (cur_hit >> 1))) begin
                        state_d    = DOOR_OPEN;
                        clear_mask = cur_hit >> 1;
                        door_d     = DOOR_LOAD;
                    end
                end else begin
                    travel_d = travel_q + 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (|(req & cur_hit)) begin
                    door_d = DOOR_LOAD;
                end else if (!overload) begin
                    if (door_q <= DOOR_W'(1)) begin
                        state_d = IDLE;
                        door_d  = '0;
                    end else begin
                        door_d = door_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = (pending_q | req_eff) & ~clear_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dir_q     <= UP;
            floor_q   <= '0;
            pending_q <= '0;
            travel_q  <= '0;
            door_q    <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            travel_q  <= travel_d;
            door_q    <= door_d;
        end
    end

    assign motor_up    = (state_q == MOVING_UP);
    assign motor_down  = (state_q == MOVING_DOWN);
    assign door_open   = (state_q == DOOR_OPEN);
    assign andar_atual = floor_q;
    assign pending     = pending_q;

    elevador_people_counter #(
        .CAPACITY(CAPACITY)
    ) u_people (
        .clk         (clk),
        .reset       (reset),
        .count_en    (door_open),
        .person_enter(person_enter),
        .person_exit (person_exit),
        .num_people  (num_people),
        .overload    (overload)
    );

endmodule

// File: tb/tb_elevador_scan.sv
// Self-checking bench for elevador_scan: directed scenarios plus a scoreboard of
// expected door-opening floors, popped whenever the door opens.
module tb_elevador_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       person_enter;
    logic       person_exit;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic [2:0] andar_atual;
    logic [7:0] pending;
    logic [3:0] num_people;
    logic       overload;

    int checks = 0;
    int errors = 0;
    int unsigned visit_q[$];
    logic door_prev = 1'b0;

    elevador_scan #(
        .N_FLOORS     (8),
        .TRAVEL_CYCLES(2),
        .DOOR_CYCLES  (4),
        .CAPACITY     (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .person_enter(person_enter),
        .person_exit (person_exit),
        .motor_up    (motor_up),
        .motor_down  (motor_down),
        .door_open   (door_open),
        .andar_atual (andar_atual),
        .pending     (pending),
        .num_people  (num_people),
        .overload    (overload)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Scoreboard: every door opening must match the next expected floor.
    always @(negedge clk) begin
        if (door_open && !door_prev) begin
            if (visit_q.size() == 0) check("visit_unexpected", andar_atual, 99);
            else check("visit_floor", andar_atual, visit_q.pop_front());
        end
        door_prev = door_open;
    end

    task automatic pulse_req(input logic [7:0] v);
        req = v;
        @(negedge clk);
        req = '0;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            check({tag, "_excl"}, 32'(motor_up) + 32'(motor_down) + 32'(door_open) <= 1, 1);
            if (!motor_up && !motor_down && !door_open && pending == '0) done = 1'b1;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic wait_moving_at(input string tag, input int f, input int budget);
        bit found;
        found = 1'b0;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clk);
            if (motor_up && andar_atual == f) found = 1'b1;
        end
        check(tag, found, 1);
    endtask

    task automatic count_door(output int n);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (!door_open) break;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int up_n;
        int door_n;
        bit seen_close;

        reset = 1'b1;
        req = '0;
        person_enter = 1'b0;
        person_exit = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_motor_up", motor_up, 0);
        check("rst_motor_down", motor_down, 0);
        check("rst_door", door_open, 0);
        check("rst_floor", andar_atual, 0);
        check("rst_pending", pending, 0);
        check("rst_people", num_people, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single call to floor 5 from floor 0.
        visit_q.push_back(5);
        pulse_req(8'h20);
        check("t1_pending", pending, 8'h20);
        check("t1_still_idle", motor_up, 0);
        up_n = 0;
        door_n = 0;
        seen_close = 1'b0;
        for (int c = 0; c < 40 && !seen_close; c++) begin
            @(negedge clk);
            if (c == 0) check("t1_latency", motor_up, 1);
            if (motor_up) begin
                check("t1_floor", andar_atual, up_n / 2);
                up_n++;
            end else if (door_open) begin
                door_n++;
                check("t1_pend_clr", pending, 0);
            end else if (door_n > 0) begin
                seen_close = 1'b1;
            end
        end
        check("t1_up_cycles", up_n, 10);
        check("t1_door_cycles", door_n, 4);
        check("t1_final_floor", andar_atual, 5);

        // SCAN order: moving up toward 6, calls at 1 and 5 arrive at floor 3.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        visit_q.push_back(5);
        visit_q.push_back(6);
        visit_q.push_back(1);
        pulse_req(8'h40);
        wait_moving_at("t2_at_floor3", 3, 40);
        pulse_req(8'h22);
        check("t2_pending", pending, 8'h62);
        run_until_idle("t2", 200);
        check("t2_final_floor", andar_atual, 1);

        // Door at the current floor, extended by a repeat call.
        visit_q.push_back(2);
        pulse_req(8'h04);
        run_until_idle("t3a", 100);
        visit_q.push_back(2);
        pulse_req(8'h04);
        check("t3_pending", pending, 8'h04);
        check("t3_closed", door_open, 0);
        @(negedge clk);
        check("t3_open", door_open, 1);
        check("t3_no_motor", motor_up | motor_down, 0);
        @(negedge clk);
        pulse_req(8'h04);
        check("t3_repeat_unlatched", pending, 0);
        count_door(door_n);
        check("t3_extend", door_n, 4);
        check("t3_floor", andar_atual, 2);

        // Occupancy: saturation at zero, cancel, overload hold, release.
        visit_q.push_back(2);
        pulse_req(8'h04);
        @(negedge clk);
        check("t4_open", door_open, 1);
        person_exit = 1'b1;
        req = 8'h04;
        @(negedge clk);
        person_exit = 1'b0;
        check("t4_exit_at_zero", num_people, 0);
        for (int i = 1; i <= 11; i++) begin
            person_enter = 1'b1;
            req = 8'h04;
            @(negedge clk);
            check("t4_count", num_people, i);
            check("t4_overload", overload, (i > 10) ? 1 : 0);
            if (i == 5) begin
                person_exit = 1'b1;
                @(negedge clk);
                person_exit = 1'b0;
                check("t4_enter_exit_same", num_people, 5);
            end
        end
        person_enter = 1'b0;
        req = '0;
        repeat (20) @(negedge clk);
        check("t4_held_open", door_open, 1);
        check("t4_held_count", num_people, 11);
        person_exit = 1'b1;
        @(negedge clk);
        person_exit = 1'b0;
        check("t4_after_exit", num_people, 10);
        check("t4_overload_clr", overload, 0);
        count_door(door_n);
        check("t4_remaining_door", door_n, 4);
        person_enter = 1'b1;
        @(negedge clk);
        person_enter = 1'b0;
        check("t4_enter_closed", num_people, 10);

        // Asynchronous reset mid-travel.
        pulse_req(8'h81);
        wait_moving_at("t5_at_floor4", 4, 40);
        check("t5_pending", pending, 8'h81);
        #2 reset = 1'b1;
        #1;
        check("t5_async_motor", motor_up, 0);
        check("t5_async_floor", andar_atual, 0);
        check("t5_async_pending", pending, 0);
        check("t5_async_people", num_people, 0);
        check("t5_async_door", door_open, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5_no_motor_up", motor_up, 0);
        check("t5_no_motor_down", motor_down, 0);
        check("t5_floor", andar_atual, 0);

        check("sb_empty", visit_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
